// File: rtl/kmap_scan_ctrl_if.sv
// Bundle of scan-controller signals: control inputs, function probe, and scan results.
// The master side drives the request and evaluates f; the slave side is the controller.
interface kmap_scan_ctrl_if;
    logic       start;
    logic       abort;
    logic [1:0] settle;
    logic [7:0] expected;
    logic [2:0] abc;
    logic       f;
    logic       busy;
    logic       done;
    logic [7:0] truth_table;
    logic       match;
    logic [3:0] ones_count;

    modport master (
        output start, abort, settle, expected, f,
        input  abc, busy, done, truth_table, match, ones_count
    );

    modport slave (
        input  start, abort, settle, expected, f,
        output abc, busy, done, truth_table, match, ones_count
    );
endinterface

// File: rtl/kmap_scan_ctrl.sv
// Walks {A,B,C} through all eight minterms of a 3-input function, captures f into a
// truth table, and compares it against a latched golden table.
module kmap_scan_ctrl (
    input logic        clk,
    input logic        reset,
    kmap_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [2:0]  index_r;
    logic [1:0]  wait_r;
    logic [1:0]  settle_r;
    logic [7:0]  expected_r;
    logic [7:0]  truth_table_r;
    logic        match_r;
    logic [3:0]  ones_count_r;

    logic        start_go_s;
    logic        sample_s;
    logic        last_s;
    logic [7:0]  tt_sampled_s;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Scan qualifiers; abort suppresses the sample so a cancelled minterm stays 0.
    always_comb begin
        start_go_s   = (state_r == IDLE) && bus.start && !bus.abort;
        sample_s     = (state_r == APPLY) && !bus.abort && (wait_r == settle_r);
        last_s       = sample_s && (index_r == 3'd7);
        tt_sampled_s = truth_table_r;
        tt_sampled_s[index_r] = bus.f;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_go_s) begin
                    next_state_s = APPLY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    next_state_s = IDLE;
                end else if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = APPLY;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Scan datapath: index/hold counter, capture, and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_r       <= 3'd0;
            wait_r        <= 2'd0;
            settle_r      <= 2'd0;
            expected_r    <= 8'd0;
            truth_table_r <= 8'd0;
            match_r       <= 1'b0;
            ones_count_r  <= 4'd0;
        end else if (start_go_s) begin
            index_r       <= 3'd0;
            wait_r        <= 2'd0;
            settle_r      <= bus.settle;
            expected_r    <= bus.expected;
            truth_table_r <= 8'd0;
            match_r       <= 1'b0;
        end else if (sample_s) begin
            truth_table_r <= tt_sampled_s;
            wait_r        <= 2'd0;
            if (last_s) begin
                match_r      <= (tt_sampled_s == expected_r);
                ones_count_r <= count_ones(tt_sampled_s);
            end else begin
                index_r <= index_r + 3'd1;
            end
        end else if ((state_r == APPLY) && !bus.abort) begin
            wait_r <= wait_r + 2'd1;
        end else if (state_r == APPLY) begin
            index_r <= 3'd0;
            wait_r  <= 2'd0;
        end else begin
            index_r <= index_r;
        end
    end

    // Outputs decoded from the registered state only, so f never reaches an output combinationally.
    always_comb begin
        bus.abc  = 3'd0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_r)
            APPLY: begin
                bus.abc  = index_r;
                bus.busy = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.abc = 3'd0;
            end
        endcase
    end

    assign bus.truth_table = truth_table_r;
    assign bus.match       = match_r;
    assign bus.ones_count  = ones_count_r;

endmodule

// File: tb/tb_kmap_scan_ctrl.sv
// Scoreboard bench for kmap_scan_ctrl: scans push expected results, a negedge monitor
// pops them on each done pulse; directed cases plus randomized scans with aborts.
module tb_kmap_scan_ctrl;

    logic clk;
    logic reset;
    logic [7:0] func_v;
    int   cyc;
    int   checks;
    int   errors;
    logic [3:0] model_ones;

    typedef struct {
        logic [7:0] tt;
        logic       m;
        logic [3:0] ones;
        int         lat;
        int         start_cyc;
    } exp_t;

    exp_t sb[$];

    kmap_scan_ctrl_if bus();

    kmap_scan_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.f = func_v[bus.abc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t it;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                it = sb.pop_front();
                chk("truth_table", {24'd0, bus.truth_table}, {24'd0, it.tt});
                chk("match", {31'd0, bus.match}, {31'd0, it.m});
                chk("ones_count", {28'd0, bus.ones_count}, {28'd0, it.ones});
                chk("done_latency", cyc - it.start_cyc, it.lat);
            end
        end
    end

    // kind: 0 = complete scan, 1 = abort at minterm kidx, 2 = reset at minterm kidx
    task automatic run_scan(input logic [7:0] fn, input logic [1:0] s, input logic [7:0] ex,
                            input int kind, input int kidx, input bit noise);
        int   per;
        int   total;
        exp_t it;
        logic [7:0] part;
        per   = int'(s) + 1;
        total = 8 * per;
        func_v       = fn;
        bus.settle   = s;
        bus.expected = ex;
        bus.start    = 1'b1;
        bus.abort    = 1'b0;
        if (kind == 0) begin
            it.tt        = fn;
            it.m         = (fn == ex);
            it.ones      = 4'($countones(fn));
            it.lat       = total;
            it.start_cyc = cyc + 1;
            sb.push_back(it);
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; t < total; t++) begin
            chk("busy_scan", {31'd0, bus.busy}, 32'd1);
            chk("abc_scan", {29'd0, bus.abc}, t / per);
            if (kind != 0 && t == kidx * per) begin
                if (kind == 1) bus.abort = 1'b1;
                else           reset = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                reset     = 1'b0;
                if (kind == 1) begin
                    part = fn & 8'((1 << kidx) - 1);
                    chk("abort_tt", {24'd0, bus.truth_table}, {24'd0, part});
                    chk("abort_ones", {28'd0, bus.ones_count}, {28'd0, model_ones});
                end else begin
                    model_ones = 4'd0;
                    chk("reset_tt", {24'd0, bus.truth_table}, 32'd0);
                    chk("reset_ones", {28'd0, bus.ones_count}, 32'd0);
                end
                chk("cancel_match", {31'd0, bus.match}, 32'd0);
                chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
                chk("cancel_abc", {29'd0, bus.abc}, 32'd0);
                chk("cancel_done", {31'd0, bus.done}, 32'd0);
                return;
            end
            if (noise) begin
                bus.settle   = 2'($urandom);
                bus.expected = 8'($urandom);
                bus.start    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
        chk("abc_in_done", {29'd0, bus.abc}, 32'd0);
        model_ones = 4'($countones(fn));
        bus.start = 1'($urandom_range(0, 1));
        bus.abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_after_done_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_after_done_done", {31'd0, bus.done}, 32'd0);
        chk("idle_holds_tt", {24'd0, bus.truth_table}, {24'd0, fn});
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        logic [7:0] fn;
        logic [7:0] ex;
        logic [1:0] s;
        int kind;
        checks       = 0;
        errors       = 0;
        model_ones   = 4'd0;
        func_v       = 8'h96;
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.abort    = 1'b0;
        bus.settle   = 2'd3;
        bus.expected = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_abc", {29'd0, bus.abc}, 32'd0);
        chk("rst_tt", {24'd0, bus.truth_table}, 32'd0);
        chk("rst_match", {31'd0, bus.match}, 32'd0);
        chk("rst_ones", {28'd0, bus.ones_count}, 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        // start and abort together in IDLE: stays idle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", {31'd0, bus.busy}, 32'd0);

        run_scan(8'h96, 2'd0, 8'h96, 0, 0, 1'b0);
        run_scan(8'h96, 2'd3, 8'h96, 0, 0, 1'b0);
        run_scan(8'h00, 2'd0, 8'h96, 0, 0, 1'b0);
        run_scan(8'hFF, 2'd1, 8'h96, 0, 0, 1'b0);
        run_scan(8'h96, 2'd0, 8'h96, 1, 4, 1'b0);
        run_scan(8'h96, 2'd0, 8'h96, 0, 0, 1'b1);
        run_scan(8'h96, 2'd2, 8'h96, 2, 5, 1'b0);
        run_scan(8'h96, 2'd0, 8'h96, 0, 0, 1'b0);

        repeat (40) begin
            fn   = 8'($urandom);
            s    = 2'($urandom_range(0, 3));
            ex   = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
            kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_scan(fn, s, ex, kind, $urandom_range(0, 7),
                     (kind == 0) && ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
